// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard-driven flash playback sequencer:
// ASCII command bytes, the sequencer state type and the default address width.
package kbd_pkg;

   localparam int ADDR_W_DFLT = 23;

   localparam logic [7:0] ASCII_E_UC = 8'h45;
   localparam logic [7:0] ASCII_E_LC = 8'h65;
   localparam logic [7:0] ASCII_D_UC = 8'h44;
   localparam logic [7:0] ASCII_D_LC = 8'h64;
   localparam logic [7:0] ASCII_F_UC = 8'h46;
   localparam logic [7:0] ASCII_F_LC = 8'h66;
   localparam logic [7:0] ASCII_B_UC = 8'h42;
   localparam logic [7:0] ASCII_B_LC = 8'h62;
   localparam logic [7:0] ASCII_R_UC = 8'h52;
   localparam logic [7:0] ASCII_R_LC = 8'h72;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SAMPLE0,
      ST_SAMPLE1
   } state_t;

endpackage

// File: rtl/kbd_cmd_decode.sv
// Combinational ASCII-to-one-hot command decode. Upper and lower case map to
// the same command; any other byte, or a byte without kbd_valid, decodes to
// no command at all.
module kbd_cmd_decode
   import kbd_pkg::*;
(
   input  logic       kbd_valid,
   input  logic [7:0] kbd_data,
   output logic       cmd_play,
   output logic       cmd_pause,
   output logic       cmd_fwd,
   output logic       cmd_bwd,
   output logic       cmd_restart
);

   // Decode the keyboard byte into at most one command strobe.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // a signal unassigned, which would otherwise infer a latch.
      cmd_play    = 1'b0;
      cmd_pause   = 1'b0;
      cmd_fwd     = 1'b0;
      cmd_bwd     = 1'b0;
      cmd_restart = 1'b0;
      if (kbd_valid) begin
         case (kbd_data)
            ASCII_E_UC, ASCII_E_LC: cmd_play    = 1'b1;
            ASCII_D_UC, ASCII_D_LC: cmd_pause   = 1'b1;
            ASCII_F_UC, ASCII_F_LC: cmd_fwd     = 1'b1;
            ASCII_B_UC, ASCII_B_LC: cmd_bwd     = 1'b1;
            ASCII_R_UC, ASCII_R_LC: cmd_restart = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/kbd_playback_ctrl.sv
// Keyboard-driven playback sequencer. Fetches one 32-bit flash word per two
// audio samples, walks the address space forward or backward with wrap, and
// paces sample output to sample_tick. All outputs come straight from flops.
module kbd_playback_ctrl
   import kbd_pkg::*;
#(
   parameter int                 ADDR_W    = ADDR_W_DFLT,
   parameter logic [ADDR_W-1:0]  LAST_ADDR = 23'h7FFFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        kbd_data,
   input  logic              kbd_valid,
   input  logic              sample_tick,
   output logic              flash_req,
   output logic [ADDR_W-1:0] flash_addr,
   input  logic              flash_ack,
   input  logic [31:0]       flash_data,
   output logic [15:0]       audio_sample,
   output logic              sample_valid,
   output logic              playing,
   output logic              dir_fwd
);

   logic cmd_play, cmd_pause, cmd_fwd, cmd_bwd, cmd_restart;

   kbd_cmd_decode u_cmd_decode (
      .kbd_valid   (kbd_valid),
      .kbd_data    (kbd_data),
      .cmd_play    (cmd_play),
      .cmd_pause   (cmd_pause),
      .cmd_fwd     (cmd_fwd),
      .cmd_bwd     (cmd_bwd),
      .cmd_restart (cmd_restart)
   );

   state_t            state_q, state_d;
   logic              playing_q, playing_d;
   logic              dir_fwd_q, dir_fwd_d;
   logic              restart_pend_q, restart_pend_d;
   logic              pend_fwd_q, pend_fwd_d;     // direction latched when the restart was deferred
   logic              flash_req_q, flash_req_d;
   logic [ADDR_W-1:0] flash_addr_q, flash_addr_d;
   logic [31:0]       word_q, word_d;
   logic              first_a_q, first_a_d;       // first half of the current word was A
   logic [15:0]       audio_q, audio_d;
   logic              sample_valid_q, sample_valid_d;

   // An ack only counts against a request we actually have outstanding.
   logic              ack_acc;
   logic              tick_acc;
   logic [ADDR_W-1:0] restart_tgt;
   logic [ADDR_W-1:0] pend_tgt;
   logic [ADDR_W-1:0] addr_step;

   assign ack_acc     = (state_q == ST_FETCH) && flash_req_q && flash_ack;
   assign tick_acc    = sample_tick && playing_q;
   assign restart_tgt = dir_fwd_q  ? '0 : LAST_ADDR;
   assign pend_tgt    = pend_fwd_q ? '0 : LAST_ADDR;
   assign addr_step   = dir_fwd_q
                        ? ((flash_addr_q == LAST_ADDR) ? '0 : flash_addr_q + 1'b1)
                        : ((flash_addr_q == '0) ? LAST_ADDR : flash_addr_q - 1'b1);

   // Command flags; they affect the FSM only from the following cycle.
   always_comb begin
      playing_d = playing_q;
      dir_fwd_d = dir_fwd_q;
      if (cmd_play)  playing_d = 1'b1;
      if (cmd_pause) playing_d = 1'b0;
      if (cmd_fwd)   dir_fwd_d = 1'b1;
      if (cmd_bwd)   dir_fwd_d = 1'b0;
   end

   // Next-state logic. A restart outside FETCH jumps straight back to the
   // fetch (or idles if paused); inside FETCH it waits for the ack and refetches.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (playing_q) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (ack_acc) state_d = (restart_pend_q || cmd_restart) ? ST_FETCH : ST_SAMPLE0;
         end
         ST_SAMPLE0: begin
            if (cmd_restart)   state_d = playing_q ? ST_FETCH : ST_IDLE;
            else if (tick_acc) state_d = ST_SAMPLE1;
         end
         ST_SAMPLE1: begin
            if (cmd_restart)   state_d = playing_q ? ST_FETCH : ST_IDLE;
            else if (tick_acc) state_d = ST_FETCH;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath and output register inputs: address counter, word capture,
   // half-word sample mux and the flash request.
   always_comb begin
      flash_addr_d   = flash_addr_q;
      word_d         = word_q;
      first_a_d      = first_a_q;
      audio_d        = audio_q;
      sample_valid_d = 1'b0;
      restart_pend_d = restart_pend_q;
      pend_fwd_d     = pend_fwd_q;

      if (state_q == ST_FETCH) begin
         if (ack_acc) begin
            if (restart_pend_q || cmd_restart) begin
               flash_addr_d   = cmd_restart ? restart_tgt : pend_tgt;
               word_d         = '0;
               restart_pend_d = 1'b0;
            end else begin
               word_d = flash_data;
            end
         end else if (cmd_restart) begin
            restart_pend_d = 1'b1;
            pend_fwd_d     = dir_fwd_q;
         end
      end else if (cmd_restart) begin
         flash_addr_d = restart_tgt;
         word_d       = '0;
      end else if (state_q == ST_SAMPLE0 && tick_acc) begin
         audio_d        = dir_fwd_q ? word_q[15:0] : word_q[31:16];
         first_a_d      = dir_fwd_q;
         sample_valid_d = 1'b1;
      end else if (state_q == ST_SAMPLE1 && tick_acc) begin
         audio_d        = first_a_q ? word_q[31:16] : word_q[15:0];
         sample_valid_d = 1'b1;
         flash_addr_d   = addr_step;
      end

      // Request drops for at least one cycle after every accepted ack, so a
      // refetch after a deferred restart never changes the address under req.
      flash_req_d = (state_d == ST_FETCH) && !ack_acc;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the pre-edge values regardless of statement order.
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Flags, datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         playing_q      <= 1'b0;
         dir_fwd_q      <= 1'b1;
         restart_pend_q <= 1'b0;
         pend_fwd_q     <= 1'b1;
         flash_req_q    <= 1'b0;
         flash_addr_q   <= '0;
         // NOTE: the word register is reset as well; it is a single register,
         // not a memory array, and a known value keeps the sample mux clean.
         word_q         <= '0;
         first_a_q      <= 1'b1;
         audio_q        <= '0;
         sample_valid_q <= 1'b0;
      end else begin
         playing_q      <= playing_d;
         dir_fwd_q      <= dir_fwd_d;
         restart_pend_q <= restart_pend_d;
         pend_fwd_q     <= pend_fwd_d;
         flash_req_q    <= flash_req_d;
         flash_addr_q   <= flash_addr_d;
         word_q         <= word_d;
         first_a_q      <= first_a_d;
         audio_q        <= audio_d;
         sample_valid_q <= sample_valid_d;
      end
   end

   assign flash_req    = flash_req_q;
   assign flash_addr   = flash_addr_q;
   assign audio_sample = audio_q;
   assign sample_valid = sample_valid_q;
   assign playing      = playing_q;
   assign dir_fwd      = dir_fwd_q;

endmodule

// File: tb/tb_kbd_playback_ctrl.sv
// Directed bench for kbd_playback_ctrl: a per-cycle vector table for the main
// playback flow plus hand-written sequences for async reset and restart-while-paused.
module tb_kbd_playback_ctrl;

   localparam int ADDR_W = 23;
   localparam logic [ADDR_W-1:0] LAST = 23'h7FFFF;

   logic              clk;
   logic              rst_n;
   logic [7:0]        kbd_data;
   logic              kbd_valid;
   logic              sample_tick;
   logic              flash_req;
   logic [ADDR_W-1:0] flash_addr;
   logic              flash_ack;
   logic [31:0]       flash_data;
   logic [15:0]       audio_sample;
   logic              sample_valid;
   logic              playing;
   logic              dir_fwd;

   kbd_playback_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .kbd_data     (kbd_data),
      .kbd_valid    (kbd_valid),
      .sample_tick  (sample_tick),
      .flash_req    (flash_req),
      .flash_addr   (flash_addr),
      .flash_ack    (flash_ack),
      .flash_data   (flash_data),
      .audio_sample (audio_sample),
      .sample_valid (sample_valid),
      .playing      (playing),
      .dir_fwd      (dir_fwd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string             name;
      logic              kv;
      logic [7:0]        kd;
      logic              tk;
      logic              ak;
      logic [31:0]       fd;
      logic              e_play;
      logic              e_dir;
      logic              e_req;
      logic [ADDR_W-1:0] e_addr;
      logic              e_sv;
      logic [15:0]       e_aud;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input string name, input logic kv, input logic [7:0] kd,
                      input logic tk, input logic ak, input logic [31:0] fd,
                      input logic e_play, input logic e_dir, input logic e_req,
                      input logic [ADDR_W-1:0] e_addr, input logic e_sv,
                      input logic [15:0] e_aud);
      vec_t v;
      v.name = name; v.kv = kv; v.kd = kd; v.tk = tk; v.ak = ak; v.fd = fd;
      v.e_play = e_play; v.e_dir = e_dir; v.e_req = e_req;
      v.e_addr = e_addr; v.e_sv = e_sv; v.e_aud = e_aud;
      vecs.push_back(v);
   endtask

   task automatic check_outputs(input string tag, input logic e_play, input logic e_dir,
                                input logic e_req, input logic [ADDR_W-1:0] e_addr,
                                input logic e_sv, input logic [15:0] e_aud);
      check({tag, ".playing"},      {31'd0, playing},      {31'd0, e_play});
      check({tag, ".dir_fwd"},      {31'd0, dir_fwd},      {31'd0, e_dir});
      check({tag, ".flash_req"},    {31'd0, flash_req},    {31'd0, e_req});
      check({tag, ".flash_addr"},   {9'd0, flash_addr},    {9'd0, e_addr});
      check({tag, ".sample_valid"}, {31'd0, sample_valid}, {31'd0, e_sv});
      check({tag, ".audio_sample"}, {16'd0, audio_sample}, {16'd0, e_aud});
   endtask

   // One cycle: drive at negedge, sample 1 time unit after the posedge.
   task automatic cycle(input logic kv, input logic [7:0] kd, input logic tk,
                        input logic ak, input logic [31:0] fd);
      @(negedge clk);
      kbd_valid = kv; kbd_data = kd; sample_tick = tk; flash_ack = ak; flash_data = fd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit seen;

      //   name            kv kd     tk ak fd            play dir req addr      sv aud
      add("play_cmd",      1, 8'h65, 0, 0, 32'h0,        1, 1, 0, 23'h0,      0, 16'h0000);
      add("idle_to_fetch", 0, 8'h00, 0, 0, 32'h0,        1, 1, 1, 23'h0,      0, 16'h0000);
      add("req_hold",      0, 8'h00, 0, 0, 32'h0,        1, 1, 1, 23'h0,      0, 16'h0000);
      add("ack_word0",     0, 8'h00, 0, 1, 32'hBBBBAAAA, 1, 1, 0, 23'h0,      0, 16'h0000);
      add("fwd_half_a",    0, 8'h00, 1, 0, 32'h0,        1, 1, 0, 23'h0,      1, 16'hAAAA);
      add("bwd_cmd",       1, 8'h62, 0, 0, 32'h0,        1, 0, 0, 23'h0,      0, 16'hAAAA);
      add("half_b_wrap",   0, 8'h00, 1, 0, 32'h0,        1, 0, 1, LAST,       1, 16'hBBBB);
      add("ack_word1",     0, 8'h00, 0, 1, 32'h11112222, 1, 0, 0, LAST,       0, 16'hBBBB);
      add("bwd_half_b",    0, 8'h00, 1, 0, 32'h0,        1, 0, 0, LAST,       1, 16'h1111);
      add("fwd_cmd",       1, 8'h46, 0, 0, 32'h0,        1, 1, 0, LAST,       0, 16'h1111);
      add("rest_a_wrap0",  0, 8'h00, 1, 0, 32'h0,        1, 1, 1, 23'h0,      1, 16'h2222);
      add("ack_word2",     0, 8'h00, 0, 1, 32'h44443333, 1, 1, 0, 23'h0,      0, 16'h2222);
      add("word2_a",       0, 8'h00, 1, 0, 32'h0,        1, 1, 0, 23'h0,      1, 16'h3333);
      add("pause_cmd",     1, 8'h44, 0, 0, 32'h0,        0, 1, 0, 23'h0,      0, 16'h3333);
      add("tick_paused0",  0, 8'h00, 1, 0, 32'h0,        0, 1, 0, 23'h0,      0, 16'h3333);
      add("tick_paused1",  0, 8'h00, 1, 0, 32'h0,        0, 1, 0, 23'h0,      0, 16'h3333);
      add("resume_cmd",    1, 8'h45, 0, 0, 32'h0,        1, 1, 0, 23'h0,      0, 16'h3333);
      add("resume_b_a1",   0, 8'h00, 1, 0, 32'h0,        1, 1, 1, 23'h1,      1, 16'h4444);
      add("byte_A_ignore", 1, 8'h41, 0, 0, 32'h0,        1, 1, 1, 23'h1,      0, 16'h4444);
      add("no_valid_D",    0, 8'h44, 0, 0, 32'h0,        1, 1, 1, 23'h1,      0, 16'h4444);
      add("restart_fetch", 1, 8'h72, 0, 0, 32'h0,        1, 1, 1, 23'h1,      0, 16'h4444);
      add("pend_req_hold", 0, 8'h00, 0, 0, 32'h0,        1, 1, 1, 23'h1,      0, 16'h4444);
      add("pend_discard",  0, 8'h00, 0, 1, 32'hDEADBEEF, 1, 1, 0, 23'h0,      0, 16'h4444);
      add("refetch_req",   0, 8'h00, 0, 0, 32'h0,        1, 1, 1, 23'h0,      0, 16'h4444);
      add("tick_in_fetch", 0, 8'h00, 1, 0, 32'h0,        1, 1, 1, 23'h0,      0, 16'h4444);
      add("ack_word3",     0, 8'h00, 0, 1, 32'h66665555, 1, 1, 0, 23'h0,      0, 16'h4444);
      add("word3_a",       0, 8'h00, 1, 0, 32'h0,        1, 1, 0, 23'h0,      1, 16'h5555);
      add("bwd_cmd2",      1, 8'h62, 0, 0, 32'h0,        1, 0, 0, 23'h0,      0, 16'h5555);
      add("restart_smp1",  1, 8'h52, 0, 0, 32'h0,        1, 0, 1, LAST,       0, 16'h5555);
      add("ack_word4",     0, 8'h00, 0, 1, 32'h88887777, 1, 0, 0, LAST,       0, 16'h5555);
      add("word4_b",       0, 8'h00, 1, 0, 32'h0,        1, 0, 0, LAST,       1, 16'h8888);
      add("pause_and_tick",1, 8'h64, 1, 0, 32'h0,        0, 0, 1, 23'h7FFFE,  1, 16'h7777);
      add("fetch_paused",  0, 8'h00, 0, 0, 32'h0,        0, 0, 1, 23'h7FFFE,  0, 16'h7777);

      rst_n = 1'b0; kbd_valid = 1'b0; kbd_data = 8'h00; sample_tick = 1'b0;
      flash_ack = 1'b0; flash_data = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_outputs("reset", 1'b0, 1'b1, 1'b0, '0, 1'b0, 16'h0000);

      foreach (vecs[i]) begin
         cycle(vecs[i].kv, vecs[i].kd, vecs[i].tk, vecs[i].ak, vecs[i].fd);
         check_outputs(vecs[i].name, vecs[i].e_play, vecs[i].e_dir, vecs[i].e_req,
                       vecs[i].e_addr, vecs[i].e_sv, vecs[i].e_aud);
      end

      // Asynchronous reset while a fetch is outstanding: no clock edge needed.
      @(negedge clk);
      kbd_valid = 1'b0; sample_tick = 1'b0; flash_ack = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_outputs("async_rst", 1'b0, 1'b1, 1'b0, '0, 1'b0, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      // Restart while paused: address reloads, FSM idles, no request.
      cycle(1'b1, 8'h42, 1'b0, 1'b0, 32'h0);
      cycle(1'b1, 8'h72, 1'b0, 1'b0, 32'h0);
      check_outputs("restart_paused", 1'b0, 1'b0, 1'b0, LAST, 1'b0, 16'h0000);

      // Resume: a request at LAST_ADDR must appear within a bounded wait.
      cycle(1'b1, 8'h65, 1'b0, 1'b0, 32'h0);
      seen = 1'b0;
      for (int n = 0; n < 8 && !seen; n++) begin
         cycle(1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
         if (flash_req) seen = 1'b1;
      end
      check("resume_req_seen", {31'd0, seen}, 32'd1);
      check("resume_req_addr", {9'd0, flash_addr}, {9'd0, LAST});
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 32'hCAFEF00D);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 32'h0);
      check_outputs("resume_b_half", 1'b1, 1'b0, 1'b0, LAST, 1'b1, 16'hCAFE);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/kbd_playback_ctrl.md
# kbd_playback_ctrl

Keyboard-driven playback sequencer for the flash audio player. It takes ASCII command bytes from the keyboard path and walks the flash sample address space forward or backward, fetching one 32-bit word per two audio samples over a req/ack handshake. It paces sample output to an external sample-rate tick and exposes play and direction status for the LEDs. It sits between the keyboard front end, the flash read master and the audio DAC/output register.

## Interface
- ADDR_W, 23, flash word-address width
- LAST_ADDR, 23'h7FFFF, final word address of the clip; addresses 0..LAST_ADDR are valid
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- kbd_data  in  8  ASCII byte from keyboard front end
- kbd_valid  in  1  one-cycle strobe, kbd_data valid
- sample_tick  in  1  one-cycle strobe at audio sample rate, already synchronous to clk
- flash_req  out  1  read request, held until flash_ack
- flash_addr  out  ADDR_W  word address, stable while flash_req high
- flash_ack  in  1  one-cycle strobe, flash_data valid
- flash_data  in  32  read word: [15:0] sample A, [31:16] sample B
- audio_sample  out  16  current signed sample, held between updates
- sample_valid  out  1  one-cycle pulse when audio_sample updates
- playing  out  1  1 = playing, 0 = paused
- dir_fwd  out  1  1 = forward, 0 = backward

## Operation
- Commands are case-insensitive, decoded on kbd_valid, and other bytes are ignored:
  - 'E'/'e' (0x45/0x65): playing<=1
  - 'D'/'d' (0x44/0x64): playing<=0
  - 'F'/'f' (0x46/0x66): dir_fwd<=1
  - 'B'/'b' (0x42/0x62): dir_fwd<=0
  - 'R'/'r' (0x52/0x72): restart
- Restart target: address 0 if dir_fwd, LAST_ADDR otherwise. Target uses dir_fwd as registered at the time of the restart.
- FSM states: IDLE, FETCH, SAMPLE0, SAMPLE1.
  - IDLE -> FETCH when playing=1.
  - FETCH: flash_req=1. On flash_ack, capture flash_data into word register and go to SAMPLE0.
  - SAMPLE0: on sample_tick with playing=1, output the first half and go to SAMPLE1.
    - First half is A if dir_fwd, else B.
  - SAMPLE1: on sample_tick with playing=1, output the other half.
    - Then step the address: +1 forward, -1 backward.
    - Wrap: LAST_ADDR+1 -> 0 and 0-1 -> LAST_ADDR.
    - Then go to FETCH.
  - sample_tick while playing=0 is ignored; state and audio_sample hold.
- Direction change takes effect at the next address step and next word's half order. The current word's remaining half is still output.
- Restart outside FETCH: flash_addr<=target, discard the word register, go to FETCH if playing else IDLE.
- Restart during FETCH: flash_req stays high until ack, with no mid-transaction abort. Set restart_pend; on ack, discard data, load target, and re-enter FETCH.
- Reset values:
  - state IDLE, flash_req 0, flash_addr 0
  - audio_sample 0, sample_valid 0
  - playing 0, dir_fwd 1, restart_pend 0
- Reset mid-FETCH drops flash_req immediately. The flash master must tolerate an abandoned request.

## Timing
- All outputs are registered.
- Command flags update on the clk edge after kbd_valid (1-cycle latency).
- flash_req rises the cycle the FSM enters FETCH and falls the cycle after flash_ack.
- flash_addr never changes while flash_req=1.
- The first cycle in SAMPLE0 is the cycle after ack.
- sample_valid pulses and audio_sample updates one cycle after the accepted sample_tick.
- sample_tick arriving in FETCH or IDLE is dropped, with no buffering.
- Flash latency must be shorter than one tick period for gapless audio.
- kbd_valid and sample_tick in the same cycle: the command applies from the next edge, and the tick is evaluated with the pre-command flags.

## Structure
- Shared package kbd_pkg:
  - ASCII command constants (upper and lower case)
  - state enum type
  - ADDR_W default
- Sub-module kbd_cmd_decode: combinational ASCII-to-one-hot command decode (play, pause, fwd, bwd, restart) gated by kbd_valid. The FSM, address counter and sample mux stay in kbd_playback_ctrl.

## Test plan
- Reset, send 'e', ack with data 0xBBBBAAAA, then two ticks:
  - flash_addr=0
  - audio_sample=0xAAAA, then 0xBBBB
  - next request at addr 1
- Send 'b' after the first forward sample, then two ticks:
  - second sample is still 0xBBBB
  - next address is 0 -1 = LAST_ADDR
  - halves of the next word come out B then A
- Forward at LAST_ADDR, two ticks: next flash_addr=0 (wrap).
- 'D' between ticks, then ticks: no sample_valid and audio_sample held. Then 'E': playback resumes from SAMPLE1.
- 'R' with flash_req high at addr 5:
  - req stays high until ack
  - data discarded, no sample_valid
  - new request at addr 0 (or LAST_ADDR after 'b')
- Byte 0x41 ('A') and kbd_valid=0 with 0x45: no flag change.
- rst_n low mid-FETCH: all outputs return to reset values asynchronously.
